// File: rtl/serial_packet_tx_pkg.sv
// Shared widths and FSM state encoding for the serial packet transmitter.
// No logic of its own; imported by the transmitter and its shifter.
// No handshake.
package serial_packet_tx_pkg;

    localparam int PORT_W    = 6;
    localparam int LEN_W     = 6;
    localparam int HDR_BITS  = 12;
    localparam int DATA_W    = 63;
    localparam int HDR_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        HEADER = 3'd2,
        DATA   = 3'd3,
        SEP    = 3'd4
    } state_t;

endpackage

// File: rtl/tx_shift_counter.sv
// Loadable LSB-first shift register with a bit counter and terminal-count flag.
// Load/shift take effect on the next rising edge; flags are combinational from the flops.
// No handshake; the owner decides when to load or shift.
module tx_shift_counter
    import serial_packet_tx_pkg::*;
#(
    parameter int W  = DATA_W,
    parameter int CW = LEN_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_dat,
    input  logic          shift,
    input  logic [CW-1:0] last_cnt,
    output logic          cur_bit,
    output logic          nxt_bit,
    output logic          tc
);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    // Load restarts the count at 0; each shift drops the bit just sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_dat;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {1'b0, sr[W-1:1]};
            cnt <= cnt + 1'b1;
        end
    end

    // cur_bit is the bit at index cnt; nxt_bit lets the owner register the next one.
    assign cur_bit = sr[0];
    assign nxt_bit = sr[1];
    assign tc      = (cnt == last_cnt);

endmodule

// File: rtl/serial_packet_tx.sv
// Serialises burst requests into start/header/data/separator frames on serout.
// Start bit appears the cycle after accept; each line bit lasts one cycle.
// req_ready only in IDLE and in SEP of a non-final burst; other requests are ignored.
module serial_packet_tx
    import serial_packet_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [PORT_W-1:0] req_port,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_last,
    output logic              serout,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              len_err
);

    state_t             state, state_nxt;
    logic               serout_q, serout_nxt;
    logic               done_nxt, underrun_nxt, len_err_nxt;
    logic [LEN_W-1:0]   len_q;
    logic               last_q;
    logic               cfg_load, last_load;
    logic               hdr_load, hdr_shift, hdr_cur, hdr_nxt, hdr_tc;
    logic               dat_load, dat_shift, dat_cur, dat_nxt, dat_tc;

    tx_shift_counter #(.W(HDR_BITS), .CW(HDR_CNT_W)) u_hdr (
        .clk      (clk),
        .rst      (rst),
        .load     (hdr_load),
        .load_dat ({req_len, req_port}),
        .shift    (hdr_shift),
        .last_cnt (HDR_CNT_W'(HDR_BITS - 1)),
        .cur_bit  (hdr_cur),
        .nxt_bit  (hdr_nxt),
        .tc       (hdr_tc)
    );

    tx_shift_counter #(.W(DATA_W), .CW(LEN_W)) u_dat (
        .clk      (clk),
        .rst      (rst),
        .load     (dat_load),
        .load_dat (req_data),
        .shift    (dat_shift),
        .last_cnt (len_q - 1'b1),
        .cur_bit  (dat_cur),
        .nxt_bit  (dat_nxt),
        .tc       (dat_tc)
    );

    // State, registered line bit, pulses and latched frame configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            serout_q <= 1'b1;
            done     <= 1'b0;
            underrun <= 1'b0;
            len_err  <= 1'b0;
            len_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            serout_q <= serout_nxt;
            done     <= done_nxt;
            underrun <= underrun_nxt;
            len_err  <= len_err_nxt;
            if (cfg_load) len_q <= req_len;
            if (cfg_load || last_load) last_q <= req_last;
        end
    end

    // Next state plus the line bit to drive in the following cycle.
    always_comb begin
        state_nxt    = state;
        serout_nxt   = 1'b1;
        done_nxt     = 1'b0;
        underrun_nxt = 1'b0;
        len_err_nxt  = 1'b0;
        cfg_load     = 1'b0;
        last_load    = 1'b0;
        hdr_load     = 1'b0;
        hdr_shift    = 1'b0;
        dat_load     = 1'b0;
        dat_shift    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        len_err_nxt = 1'b1;
                    end else begin
                        cfg_load   = 1'b1;
                        hdr_load   = 1'b1;
                        dat_load   = 1'b1;
                        serout_nxt = 1'b0;
                        state_nxt  = START;
                    end
                end
            end
            START: begin
                serout_nxt = hdr_cur;
                state_nxt  = HEADER;
            end
            HEADER: begin
                if (hdr_tc) begin
                    serout_nxt = dat_cur;
                    state_nxt  = DATA;
                end else begin
                    serout_nxt = hdr_nxt;
                    hdr_shift  = 1'b1;
                end
            end
            DATA: begin
                if (dat_tc) begin
                    state_nxt = SEP;
                end else begin
                    serout_nxt = dat_nxt;
                    dat_shift  = 1'b1;
                end
            end
            SEP: begin
                if (last_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (req_valid) begin
                    dat_load   = 1'b1;
                    last_load  = 1'b1;
                    serout_nxt = req_data[0];
                    state_nxt  = DATA;
                end else begin
                    underrun_nxt = 1'b1;
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The separator reports whether a continuation is offered in this very cycle,
    // so it bypasses the flop; every other line bit comes straight from serout_q.
    assign serout    = (state == SEP) ? (last_q | ~req_valid) : serout_q;
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) || ((state == SEP) && !last_q);

endmodule

// File: doc/serial_packet_tx.md
SERIAL_PACKET_TX -- requirements
Module: serial_packet_tx

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed constants from the shared package.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  burst request present.
REQ-005 req_ready  output  1  burst request accepted on this edge when req_valid is also high.
REQ-006 req_port  input  6  destination port; used only on the first burst of a frame.
REQ-007 req_len  input  6  data bits per burst; used only on the first burst of a frame.
REQ-008 req_data  input  63  burst payload, bit 0 sent first.
REQ-009 req_last  input  1  1 = this burst ends the frame.
REQ-010 serout  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse on frame completion.
REQ-013 underrun  output  1  one-cycle pulse, continuation burst missing at separator.
REQ-014 len_err  output  1  one-cycle pulse, request with req_len=0 refused.

Function
REQ-015 Frame format SHALL be: start bit 0; 12 header bits LSB-first (port[0..5], then len[0..5]); len data bits; separator bit (0 = another len-bit burst follows, 1 = end).
REQ-016 The FSM SHALL have the states IDLE, START, HEADER, DATA and SEP; serout SHALL be 1 in IDLE.
REQ-017 req_ready SHALL be high in IDLE, and in SEP when the current burst has last=0; it SHALL be low otherwise.
REQ-018 IDLE: an accept with req_len!=0 SHALL latch port, len, data and last, then go to START.
REQ-019 IDLE: an accept with req_len=0 SHALL pulse len_err, stay in IDLE and leave serout at 1.
REQ-020 Accept at edge T: serout SHALL be 0 for cycle T+1, header for T+2..T+13, data for T+14..T+13+len, separator at T+14+len.
REQ-021 HEADER SHALL use a 4-bit counter, exiting after count 11; DATA SHALL use a 6-bit counter, exiting after count len-1.
REQ-022 SEP with last=1: serout SHALL be 1, the next state SHALL be IDLE, and done SHALL pulse in the first IDLE cycle.
REQ-023 SEP with last=0 and req_valid=1: serout SHALL be 0, req_data/req_last SHALL be latched, and the next state SHALL be DATA.
REQ-024 On continuation bursts, req_port and req_len SHALL be ignored.
REQ-025 SEP with last=0 and req_valid=0: serout SHALL be 1 (frame terminated), underrun SHALL pulse, done SHALL pulse, and the next state SHALL be IDLE.
REQ-026 At least one idle-high cycle SHALL separate frames; back-to-back accept is allowed in the first IDLE cycle.
REQ-027 Requests presented while req_ready=0 SHALL be ignored and not accepted.

Reset
REQ-028 rst SHALL immediately force state=IDLE, serout=1, busy=0, done=0, underrun=0, len_err=0, and counters/shift registers to 0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; req_ready SHALL be 1 from the first cycle after release.

Structure
REQ-030 The shared package SHALL hold the state enum and the constants PORT_W=6, LEN_W=6, HDR_BITS=12, DATA_W=63.
REQ-031 The payload and header shifting SHALL live in one sub-module, tx_shift_counter (loadable LSB-first shift register with bit counter and terminal-count flag).

Verification
REQ-032 Single burst: port=5, len=3, data=3'b101, last=1. Required serout after accept: 0 | 1,0,1,0,0,0 | 1,1,0,0,0,0 | 1,0,1 | 1. done pulses once; busy is high for 17 cycles.
REQ-033 Two bursts: len=2, data=2'b10 last=0, then data=2'b01 last=1 valid at SEP. Required data/separator bits: 0,1 | 0 | 1,0 | 1. One done, no underrun.
REQ-034 Underrun: len=4, last=0, req_valid low at SEP. Required: separator bit 1, underrun and done pulse together, then return to IDLE.
REQ-035 req_len=0 in IDLE. Required: len_err pulse, serout stays 1, busy stays 0.
REQ-036 rst asserted during DATA bit 2 of len=10. Required: serout=1 and busy=0 at once, no done pulse, and a new frame completes correctly afterwards.
REQ-037 len=63, data all ones, req_valid held high for back-to-back frames. Required per frame: 63 ones then separator 1; exactly one idle-high cycle before the next start bit.
